ntt_unload: RTL

- Reader at the far end of the NTT datapath.
- After the address generator finishes the last stage, this block reads the N final coefficients out of the ping-pong RAM bank pair holding the result.
- It streams them in natural order on a valid/ready output port, with full backpressure support.
- It owns the RAM read ports only while busy; the address generator owns them otherwise.

---
 rtl/ntt_unload_pkg.sv | 20 ++
 rtl/ntt_unload_fifo2.sv | 59 +++++
 rtl/ntt_unload.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ntt_unload_pkg.sv
// Shared constants and FSM encoding for the NTT result unloader.
//   N_LOG / N   : log2 of the coefficient count, and the count itself
//   DATA_W      : coefficient width
//   ADDR_W      : per-bank address width (each bank holds N/2 words)
//   state_t     : unloader FSM states
package ntt_unload_pkg;

  localparam int N_LOG  = 8;
  localparam int N      = 1 << N_LOG;
  localparam int DATA_W = 16;
  localparam int ADDR_W = N_LOG - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ntt_unload_fifo2.sv
// Two-entry synchronous FIFO carrying {last, data}. The head entry is a
// dedicated register so the consumer sees data/last straight from flops.
//   clk, rst_n            : clock, synchronous active-low reset
//   push, push_data/last  : write side (caller guarantees no overflow)
//   pop                   : consume head (caller guarantees non-empty)
//   head_data/last/valid  : current head entry
//   count                 : occupancy 0..2
module ntt_unload_fifo2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic              head_valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] tail_data;
  logic              tail_last;

  assign head_valid = (count != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      // A full FIFO being popped promotes the tail into the head.
      if (pop && count == 2'd2) begin
        head_data <= tail_data;
        head_last <= tail_last;
      end
      // New data lands in the head only when the head is (or becomes) free.
      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          head_data <= push_data;
          head_last <= push_last;
        end else begin
          tail_data <= push_data;
          tail_last <= push_last;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ntt_unload.sv
// Reads the N final NTT coefficients out of the selected ping-pong bank pair
// and streams them in natural order on a valid/ready port.
//   clk, rst_n             : clock, synchronous active-low reset
//   start, src_sel         : begin an unload; pair select (0: ram0/1, 1: ram2/3)
//   ram_en, ram_addr       : bank read enables and shared read address
//   ram0_dout..ram3_dout   : bank read data, one cycle after enable
//   dout, dout_valid,
//   dout_ready, dout_last  : coefficient stream, last tags coefficient N-1
//   busy, done             : run status, one-cycle completion pulse
module ntt_unload #(
  parameter int N_LOG  = ntt_unload_pkg::N_LOG,
  parameter int DATA_W = ntt_unload_pkg::DATA_W,
  parameter int ADDR_W = N_LOG - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              src_sel,
  output logic [3:0]        ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram0_dout,
  input  logic [DATA_W-1:0] ram1_dout,
  input  logic [DATA_W-1:0] ram2_dout,
  input  logic [DATA_W-1:0] ram3_dout,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  import ntt_unload_pkg::*;

  state_t            state, state_nxt;
  logic [N_LOG-1:0]  rd_idx;
  logic              src_q;
  logic [ADDR_W-1:0] addr_q;
  logic              issue, pop, last_idx;
  logic [2:0]        credit;
  logic [1:0]        fifo_cnt;
  logic              vld_p1, bank_p1, last_p1;
  logic [DATA_W-1:0] data_p1;

  assign pop      = dout_valid & dout_ready;
  assign last_idx = &rd_idx;
  // Slots that will be claimed once this cycle settles; a new read may only
  // issue if one of the two buffer entries is still unclaimed.
  assign credit   = {1'b0, fifo_cnt} + {2'b0, vld_p1} - {2'b0, pop};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)                state_nxt = RUN;
      RUN:     if (issue && last_idx)    state_nxt = DRAIN;
      DRAIN:   if (pop && dout_last)     state_nxt = DONE;
      DONE:                              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
    issue    = (state == RUN) && (credit < 3'd2);
    ram_en   = 4'b0000;
    ram_addr = addr_q;
    if (issue) begin
      ram_en   = 4'b0001 << {src_q, rd_idx[0]};
      ram_addr = rd_idx[N_LOG-1:1];
    end
  end

  // p0: read issue -- index counter, held address and in-flight tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_idx  <= '0;
      src_q   <= 1'b0;
      addr_q  <= '0;
      vld_p1  <= 1'b0;
      bank_p1 <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        rd_idx <= '0;
        src_q  <= src_sel;
      end else if (issue) begin
        addr_q <= rd_idx[N_LOG-1:1];
        if (!last_idx) rd_idx <= rd_idx + 1'b1;
      end
      vld_p1 <= issue;
      if (issue) begin
        bank_p1 <= rd_idx[0];
        last_p1 <= last_idx;
      end
    end
  end

  // p1: bank data returns; pick the bank the in-flight read targeted
  always_comb begin
    case ({src_q, bank_p1})
      2'b00:   data_p1 = ram0_dout;
      2'b01:   data_p1 = ram1_dout;
      2'b10:   data_p1 = ram2_dout;
      default: data_p1 = ram3_dout;
    endcase
  end

  // p2: output buffer drives the stream
  ntt_unload_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (vld_p1),
    .push_data  (data_p1),
    .push_last  (last_p1),
    .pop        (pop),
    .head_data  (dout),
    .head_last  (dout_last),
    .head_valid (dout_valid),
    .count      (fifo_cnt)
  );

endmodule
